// File: rtl/vec_mem_arbiter.sv
// Sequences CPU vector/scalar accesses and host single-word accesses onto one
// single-ported synchronous scratchpad. Optional counters: VEC_MEM_ARB_PERF_EN.
module vec_mem_arbiter #(
  parameter int unsigned ADDR_W        = 13,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned LANES         = 16,
  parameter int unsigned HOST_MAX_WAIT = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_req,
  input  logic                            cpu_we,
  input  logic                            cpu_vs,
  input  logic [ADDR_W-1:0]               cpu_addr,
  input  logic [LANES-1:0][DATA_W-1:0]    cpu_wdata,
  output logic [LANES-1:0][DATA_W-1:0]    cpu_rdata,
  output logic                            cpu_stall,
  output logic                            cpu_done,
  input  logic                            host_req,
  input  logic                            host_we,
  input  logic [ADDR_W-1:0]               host_addr,
  input  logic [DATA_W-1:0]               host_wdata,
  output logic                            host_gnt,
  output logic [DATA_W-1:0]               host_rdata,
  output logic                            host_rvalid,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata
`ifdef VEC_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_stall_cyc,
  output logic [15:0]                     perf_host_gnt
`endif
);

  localparam int unsigned BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WAIT_W = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(HOST_MAX_WAIT);
  localparam logic [BEAT_W-1:0] LAST_LANE = BEAT_W'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CPU_BEAT,
    CPU_WAIT,
    CPU_DONE,
    HOST_ACC,
    HOST_RD
  } state_t;

  state_t                         state, state_n;
  logic [BEAT_W-1:0]              beat;
  logic [BEAT_W-1:0]              lane;
  logic                           lat_we;
  logic                           lat_vs;
  logic [ADDR_W-1:0]              lat_addr;
  logic [LANES-1:0][DATA_W-1:0]   lat_wdata;
  logic                           cap_pend;
  logic                           cap_scalar;
  logic [BEAT_W-1:0]              cap_lane;
  logic [DATA_W-1:0]              host_rdata_q;
  logic [WAIT_W-1:0]              wait_cnt;
  logic                           host_win;
  logic                           cpu_win;

  // Beat k drives element k, which lives in lane LANES-1-k.
  assign lane      = LAST_LANE - beat;
  assign host_win  = host_req && (!cpu_req || (wait_cnt >= WAIT_MAX));
  assign cpu_win   = !host_win && cpu_req;
  assign cpu_stall = cpu_req && (state != CPU_DONE);
  // RAM data arrives in HOST_RD itself, so forward it while rvalid is high.
  assign host_rdata = (state == HOST_RD) ? mem_rdata : host_rdata_q;

  always_comb begin
    state_n     = state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cpu_done    = 1'b0;
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    case (state)
      IDLE: begin
        if (host_win)     state_n = HOST_ACC;
        else if (cpu_win) state_n = CPU_BEAT;
      end
      CPU_BEAT: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr + ADDR_W'(beat);
        mem_wdata = lat_wdata[lane];
        if (beat == (lat_vs ? LAST_LANE : '0)) state_n = CPU_WAIT;
      end
      CPU_WAIT: state_n = CPU_DONE;
      CPU_DONE: begin
        cpu_done = 1'b1;
        state_n  = IDLE;
      end
      HOST_ACC: begin
        host_gnt  = 1'b1;
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        state_n   = host_we ? IDLE : HOST_RD;
      end
      HOST_RD: begin
        host_rvalid = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      beat         <= '0;
      lat_we       <= 1'b0;
      lat_vs       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      cap_pend     <= 1'b0;
      cap_scalar   <= 1'b0;
      cap_lane     <= '0;
      cpu_rdata    <= '0;
      host_rdata_q <= '0;
      wait_cnt     <= '0;
    end else begin
      state <= state_n;

      if (state == IDLE && cpu_win) begin
        lat_we    <= cpu_we;
        lat_vs    <= cpu_vs;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        beat      <= '0;
      end else if (state == CPU_BEAT) begin
        beat <= beat + 1'b1;
      end

      cap_pend   <= (state == CPU_BEAT) && !lat_we;
      cap_scalar <= !lat_vs;
      cap_lane   <= lane;
      if (cap_pend) begin
        if (cap_scalar) begin
          cpu_rdata            <= '0;
          cpu_rdata[LANES-1]   <= mem_rdata;
        end else begin
          cpu_rdata[cap_lane]  <= mem_rdata;
        end
      end

      if (state == HOST_RD) host_rdata_q <= mem_rdata;

      if (state == HOST_ACC)
        wait_cnt <= '0;
      else if (host_req && (wait_cnt < WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef VEC_MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_host_gnt  <= '0;
    end else begin
      if (cpu_stall) perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (host_gnt)  perf_host_gnt  <= perf_host_gnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Directed bench for vec_mem_arbiter with a behavioural synchronous RAM.
module tb_vec_mem_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned NL = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      cpu_req, cpu_we, cpu_vs;
  logic [AW-1:0]             cpu_addr;
  logic [NL-1:0][DW-1:0]     cpu_wdata;
  logic [NL-1:0][DW-1:0]     cpu_rdata;
  logic                      cpu_stall, cpu_done;
  logic                      host_req, host_we;
  logic [AW-1:0]             host_addr;
  logic [DW-1:0]             host_wdata;
  logic                      host_gnt;
  logic [DW-1:0]             host_rdata;
  logic                      host_rvalid;
  logic                      mem_en, mem_we;
  logic [AW-1:0]             mem_addr;
  logic [DW-1:0]             mem_wdata;
  logic [DW-1:0]             mem_rdata;
`ifdef VEC_MEM_ARB_PERF_EN
  logic [31:0]               perf_stall_cyc;
  logic [15:0]               perf_host_gnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vec_mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .LANES(NL),
    .HOST_MAX_WAIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_vs(cpu_vs),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .cpu_done(cpu_done),
    .host_req(host_req),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_gnt(host_gnt),
    .host_rdata(host_rdata),
    .host_rvalid(host_rvalid),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VEC_MEM_ARB_PERF_EN
    ,
    .perf_stall_cyc(perf_stall_cyc),
    .perf_host_gnt(perf_host_gnt)
`endif
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [NL*DW-1:0] act,
                       input logic [NL*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rdata"}, cpu_rdata, '0);
    check({tag, " ctl"}, {cpu_stall, cpu_done, host_gnt, host_rdata, host_rvalid,
                          mem_en, mem_we, mem_addr, mem_wdata}, '0);
  endtask

  // Drives one CPU access from an IDLE cycle (T) and checks every cycle up to
  // cpu_done at T+N+2; ends on the following idle cycle.
  task automatic cpu_run(input logic we, input logic vs, input logic [AW-1:0] addr,
                         input logic [NL-1:0][DW-1:0] wd, input string tag,
                         output logic [NL-1:0][DW-1:0] rd);
    int unsigned n;
    logic [AW-1:0] ea;
    n = vs ? NL : 1;
    cpu_req = 1'b1; cpu_we = we; cpu_vs = vs; cpu_addr = addr; cpu_wdata = wd;
    #1;
    check({tag, " stall T"}, {cpu_stall, cpu_done}, 2'b10);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      ea = addr + AW'(k);
      check({tag, " beat"}, {cpu_stall, cpu_done, mem_en, mem_we, mem_addr,
                             (we ? mem_wdata : 32'h0)},
            {1'b1, 1'b0, 1'b1, we, ea, (we ? wd[NL-1-k] : 32'h0)});
    end
    @(negedge clk);
    check({tag, " wait"}, {cpu_stall, cpu_done, mem_en, mem_we}, 4'b1000);
    @(negedge clk);
    check({tag, " done"}, {cpu_stall, cpu_done, mem_en}, 3'b010);
    rd = cpu_rdata;
    cpu_req = 1'b0;
    @(negedge clk);
    check({tag, " idle"}, {cpu_stall, cpu_done, mem_en}, 3'b000);
  endtask

  task automatic host_run(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string tag,
                          output logic [DW-1:0] rd);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    rd = '0;
    @(negedge clk);
    check({tag, " gnt"}, {host_gnt, host_rvalid, mem_en, mem_we, mem_addr,
                          (we ? mem_wdata : 32'h0)},
          {1'b1, 1'b0, 1'b1, we, a, (we ? d : 32'h0)});
    host_req = 1'b0;
    if (!we) begin
      @(negedge clk);
      check({tag, " rvalid"}, {host_gnt, host_rvalid, mem_en}, 3'b010);
      rd = host_rdata;
    end
    @(negedge clk);
    check({tag, " idle"}, {host_gnt, host_rvalid, mem_en}, 3'b000);
  endtask

  logic [NL-1:0][DW-1:0] wd, rd, exp_v;
  logic [DW-1:0]         hrd;
  int                    gnt_cyc, dones, dones_at_gnt, rv_cyc;
  logic [DW-1:0]         rv_data;

  initial begin
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_vs = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Vector write 0x100, element k = 0xA000+k
    for (int unsigned k = 0; k < NL; k++) wd[NL-1-k] = 32'hA000 + k;
    cpu_run(1'b1, 1'b1, 13'h0100, wd, "vwr", rd);
    check("ram 0x100", ram[13'h0100], 32'hA000);
    check("ram 0x107", ram[13'h0107], 32'hA007);
    check("ram 0x10F", ram[13'h010F], 32'hA00F);

    // Vector read back
    cpu_run(1'b0, 1'b1, 13'h0100, '0, "vrd", rd);
    check("vrd data", rd, wd);

    // Scalar read clears the other lanes
    exp_v = '0;
    exp_v[NL-1] = 32'hA005;
    cpu_run(1'b0, 1'b0, 13'h0105, '0, "srd", rd);
    check("srd data", rd, exp_v);

    // Wrapping vector write
    for (int unsigned k = 0; k < NL; k++) wd[NL-1-k] = 32'hC000 + k;
    cpu_run(1'b1, 1'b1, 13'h1FFE, wd, "wrap", rd);
    check("ram 0x1FFE", ram[13'h1FFE], 32'hC000);
    check("ram 0x1FFF", ram[13'h1FFF], 32'hC001);
    check("ram 0x0000", ram[13'h0000], 32'hC002);
    check("ram 0x000D", ram[13'h000D], 32'hC00F);

    // Host write then read
    host_run(1'b1, 13'h0020, 32'hDEADBEEF, "hwr", hrd);
    host_run(1'b0, 13'h0020, 32'h0, "hrd", hrd);
    check("hrd data", hrd, 32'hDEADBEEF);

    // Back-to-back scalar CPU reads vs continuous host write: cap hit at C8
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_vs = 1'b0; cpu_addr = 13'h0100; cpu_wdata = '0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0205; host_wdata = 32'h55555555;
    gnt_cyc = -1; dones = 0; dones_at_gnt = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (host_gnt) begin
        gnt_cyc = c; dones_at_gnt = dones; host_req = 1'b0;
      end
      if (cpu_done) begin
        dones++;
        if (gnt_cyc >= 0) begin
          cpu_req = 1'b0;
          break;
        end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    check("arb scalar gnt cycle", gnt_cyc, 9);
    check("arb scalar dones", dones_at_gnt, 2);
    @(negedge clk);
    check("ram 0x205", ram[13'h0205], 32'h55555555);

    // Vector CPU reads vs continuous host read: host waits for whole vector
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_vs = 1'b1; cpu_addr = 13'h0100;
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0020;
    gnt_cyc = -1; rv_cyc = -1; rv_data = '0; dones = 0; dones_at_gnt = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (host_gnt) begin
        gnt_cyc = c; dones_at_gnt = dones; host_req = 1'b0;
      end
      if (host_rvalid) begin
        rv_cyc = c; rv_data = host_rdata;
      end
      if (cpu_done) begin
        dones++;
        if (gnt_cyc >= 0) begin
          cpu_req = 1'b0;
          break;
        end
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    check("arb vector gnt cycle", gnt_cyc, 20);
    check("arb vector dones", dones_at_gnt, 1);
    check("arb vector rvalid cycle", rv_cyc, 21);
    check("arb vector rdata", rv_data, 32'hDEADBEEF);
    @(negedge clk);

    // Reset during a vector write: edge that would start beat 5 is a reset edge
    for (int unsigned k = 0; k < NL; k++) wd[NL-1-k] = 32'hB000 + k;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vs = 1'b1; cpu_addr = 13'h0200; cpu_wdata = wd;
    repeat (5) @(negedge clk);
    check("rst beat4", {mem_en, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b1, 13'h0204, 32'hB004});
    rst = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b1;
    @(negedge clk);
    check("ram 0x200", ram[13'h0200], 32'hB000);
    check("ram 0x204", ram[13'h0204], 32'hB004);
    check("ram 0x205 kept", ram[13'h0205], 32'h55555555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
